seq_dispatch_4out_roundrobin: RTL

Round-robin dispatcher that takes one val/rdy message stream and distributes each message to exactly one of four consumer ports. It is the split-side counterpart of the 4-input round-robin arbiter: the arbiter merges requesters onto one resource, and this block fans one producer out to four workers. A 2-entry input queue decouples `in_rdy` from the consumers. Selection is round-robin among the consumers that are ready, and priority rotates past each served port.

---
 rtl/seq_dispatch_4out_roundrobin_if.sv | 30 +++
 rtl/seq_dispatch_4out_roundrobin.sv | 105 ++++++++++
 2 files changed

// File: rtl/seq_dispatch_4out_roundrobin_if.sv
// Producer/consumer bus for the 4-output round-robin dispatcher.
// The master modport is the environment side; the slave modport is the dispatcher side.
interface seq_dispatch_4out_roundrobin_if #(
   parameter int unsigned NBITS = 8
);
   logic             in_val;
   logic             in_rdy;
   logic [NBITS-1:0] in_msg;
   logic [3:0]       out_val;
   logic [3:0]       out_rdy;
   logic [NBITS-1:0] out_msg;

   modport master (
      output in_val,
      output in_msg,
      output out_rdy,
      input  in_rdy,
      input  out_val,
      input  out_msg
   );

   modport slave (
      input  in_val,
      input  in_msg,
      input  out_rdy,
      output in_rdy,
      output out_val,
      output out_msg
   );
endinterface

// File: rtl/seq_dispatch_4out_roundrobin.sv
// Round-robin dispatcher: one val/rdy input stream fanned out to four consumer ports.
// A 2-entry queue decouples in_rdy from the consumers; the head message is offered to the
// first ready port at or after the rotating priority position.
module seq_dispatch_4out_roundrobin #(
   parameter int unsigned NBITS = 8
) (
   input logic                           clk,
   input logic                           reset,
   seq_dispatch_4out_roundrobin_if.slave bus
);

   logic [NBITS-1:0] data_q [2];
   logic [NBITS-1:0] data_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [3:0]       prio_q, prio_d;

   logic [3:0]       grant;
   logic [1:0]       start_idx;
   logic             prio_ok;
   logic             found;
   logic [1:0]       idx;
   logic             enq;
   logic             deq;

   // Grant: first ready port scanning upward from the priority position, with wrap.
   always_comb begin
      grant     = 4'b0000;
      start_idx = 2'd0;
      prio_ok   = 1'b1;
      found     = 1'b0;
      idx       = 2'd0;
      case (prio_q)
         4'b0001: start_idx = 2'd0;
         4'b0010: start_idx = 2'd1;
         4'b0100: start_idx = 2'd2;
         4'b1000: start_idx = 2'd3;
         default: prio_ok   = 1'b0;  // unreachable encodings dispatch nothing
      endcase
      if ((count_q != 2'd0) && prio_ok) begin
         for (int k = 0; k < 4; k++) begin
            idx = start_idx + 2'(k);
            if (!found && bus.out_rdy[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   // Handshake outputs; in_rdy depends on registered occupancy only.
   always_comb begin
      bus.out_val = grant;
      bus.out_msg = data_q[rd_ptr_q];
      bus.in_rdy  = (count_q != 2'd2);
   end

   // Queue and priority next state.
   always_comb begin
      enq       = bus.in_val && (count_q != 2'd2);
      deq       = |(grant & bus.out_rdy);
      data_d    = data_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      prio_d    = prio_q;
      if (enq) begin
         data_d[wr_ptr_q] = bus.in_msg;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (deq) begin
         rd_ptr_d = ~rd_ptr_q;
         // Rotating the one-hot grant left by one yields the port after the served one.
         prio_d   = {grant[2:0], grant[3]};
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         prio_q   <= 4'b0001;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         prio_q   <= prio_d;
      end
   end

   // Payload storage needs no reset; entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
   end

endmodule
